// File: rtl/char_rom_pkg.sv
// Shared widths and read latency for the character ROM reader.
// CHAR_ROM_OUTREG_EN selects a ROM with its output register (two-cycle read).
package char_rom_pkg;

   localparam int CHAR_W_D = 7;
   localparam int ROW_W_D  = 4;
   localparam int DATA_W_D = 8;
   localparam int ADDR_W_D = CHAR_W_D + ROW_W_D;
   localparam int DEPTH_D  = 4;

`ifdef CHAR_ROM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

endpackage

// File: rtl/char_rom_reader_if.sv
// Request/response handshake bundle between a client and the reader.
// master = client side, slave = reader side.
interface char_rom_reader_if
   import char_rom_pkg::*;
#(
   parameter int CHAR_W = CHAR_W_D,
   parameter int ROW_W  = ROW_W_D,
   parameter int DATA_W = DATA_W_D
) ();

   logic              req_valid;
   logic              req_ready;
   logic [CHAR_W-1:0] req_char;
   logic [ROW_W-1:0]  req_row;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic [ROW_W-1:0]  rsp_row;

   modport master (
      output req_valid,
      output req_char,
      output req_row,
      output rsp_ready,
      input  req_ready,
      input  rsp_valid,
      input  rsp_data,
      input  rsp_row
   );

   modport slave (
      input  req_valid,
      input  req_char,
      input  req_row,
      input  rsp_ready,
      output req_ready,
      output rsp_valid,
      output rsp_data,
      output rsp_row
   );

endinterface

// File: rtl/char_rom_rsp_fifo.sv
// Response buffer: DEPTH-entry FIFO with wrapping pointers and occupancy count.
// Head reads as zero when empty; caller never pushes when full.
module char_rom_rsp_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 12
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  logic [W-1:0]               i_data,
   input  logic                       i_pop,
   output logic [W-1:0]               o_data,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [W-1:0]     r_mem [DEPTH];
   logic [AW-1:0]    r_wp;
   logic [AW-1:0]    r_rp;
   logic [CNT_W-1:0] r_cnt;
   logic             w_pop;

   assign w_pop = i_pop && (r_cnt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wp] <= i_data;
            r_wp        <= r_wp + AW'(1);
         end
         if (w_pop) begin
            r_rp <= r_rp + AW'(1);
         end
         unique case ({i_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_data  = (r_cnt != '0) ? r_mem[r_rp] : '0;
   assign o_count = r_cnt;

endmodule

// File: rtl/char_rom_reader.sv
// Issues glyph-row reads to a synchronous character ROM and buffers replies.
// Read latency set by CHAR_ROM_OUTREG_EN (see char_rom_pkg).
module char_rom_reader
   import char_rom_pkg::*;
#(
   parameter int CHAR_W = CHAR_W_D,
   parameter int ROW_W  = ROW_W_D,
   parameter int DATA_W = DATA_W_D,
   parameter int DEPTH  = DEPTH_D
) (
   input  logic                    clk,
   input  logic                    rst_n,
   char_rom_reader_if.slave        bus,
   output logic [CHAR_W+ROW_W-1:0] rom_addr,
   output logic                    rom_clk_en,
   input  logic [DATA_W-1:0]       rom_data,
   output logic                    busy
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W:0] DEPTH_C = DEPTH[CNT_W:0];

   logic [LAT:0]            r_vld;
   logic [LAT:0][ROW_W-1:0] r_row;
   logic [CHAR_W+ROW_W-1:0] r_addr;

   logic                    w_acc;
   logic                    w_push;
   logic                    w_pop;
   logic [CNT_W-1:0]        w_count;
   logic [CNT_W-1:0]        w_inflight;
   logic [CNT_W:0]          w_need;
   logic [ROW_W+DATA_W-1:0] w_head;

   // Stage 0 is the ROM issue cycle; stage LAT holds the cycle rom_data is valid.
   assign w_inflight = CNT_W'($countones(r_vld));
   assign w_need     = {1'b0, w_inflight} + {1'b0, w_count};
   assign bus.req_ready = (w_need < DEPTH_C);
   assign w_acc      = bus.req_valid && bus.req_ready;
   assign w_push     = r_vld[LAT];
   assign w_pop      = bus.rsp_valid && bus.rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld  <= '0;
         r_row  <= '0;
         r_addr <= '0;
      end else begin
         r_vld <= {r_vld[LAT-1:0], w_acc};
         r_row <= {r_row[LAT-1:0], bus.req_row};
         if (w_acc) begin
            r_addr <= {bus.req_char, bus.req_row};
         end
      end
   end

   assign rom_addr   = r_addr;
   assign rom_clk_en = r_vld[0];

   char_rom_rsp_fifo #(
      .DEPTH (DEPTH),
      .W     (ROW_W + DATA_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  ({r_row[LAT], rom_data}),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_count (w_count)
   );

   assign bus.rsp_valid = (w_count != '0);
   assign {bus.rsp_row, bus.rsp_data} = w_head;
   assign busy = (r_vld != '0) || (w_count != '0);

endmodule

// File: tb/tb_char_rom_reader.sv
// Scoreboard bench for char_rom_reader with a behavioural ROM model.
// Build with or without CHAR_ROM_OUTREG_EN; expected latency follows LAT.
module tb_char_rom_reader;
   import char_rom_pkg::*;

   localparam int CW = 7;
   localparam int RW = 4;
   localparam int DW = 8;
   localparam int AW = CW + RW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [AW-1:0] rom_addr;
   logic          rom_clk_en;
   logic [DW-1:0] rom_data;
   logic          busy;
   logic [DW-1:0] rom_q1;
   logic [DW-1:0] rom_q2;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int acc_cnt = 0;
   logic [RW+DW-1:0] exp_q[$];
   int pop_cyc[$];

   char_rom_reader_if #(.CHAR_W(CW), .ROW_W(RW), .DATA_W(DW)) bus ();

   char_rom_reader #(
      .CHAR_W(CW), .ROW_W(RW), .DATA_W(DW), .DEPTH(4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .rom_addr   (rom_addr),
      .rom_clk_en (rom_clk_en),
      .rom_data   (rom_data),
      .busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] glyph(input logic [AW-1:0] a);
      int v;
      v = int'(a) * 37 + (int'(a) >> 5);
      return v[7:0] ^ 8'h5A;
   endfunction

   // ROM: address latched on clock-enabled edges, optional free-running output reg
   always @(posedge clk) begin
      if (rom_clk_en) rom_q1 <= glyph(rom_addr);
      rom_q2 <= rom_q1;
   end
   assign rom_data = (LAT == 2) ? rom_q2 : rom_q1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Issue side of the scoreboard: each accepted request yields {row, ROM[{char,row}]}
   always @(negedge clk) begin
      if (rst_n && bus.req_valid && bus.req_ready) begin
         exp_q.push_back({bus.req_row, glyph({bus.req_char, bus.req_row})});
         acc_cnt++;
      end
   end

   logic          hold = 1'b0;
   logic [RW+DW-1:0] hold_v;
   always @(negedge clk) begin
      if (!rst_n) begin
         hold = 1'b0;
      end else begin
         if (hold) begin
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_word", 32'({bus.rsp_row, bus.rsp_data}), 32'(hold_v));
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", 32'({bus.rsp_row, bus.rsp_data}), 32'hFFFF);
            end else begin
               chk("rsp_word", 32'({bus.rsp_row, bus.rsp_data}), 32'(exp_q.pop_front()));
            end
            pop_cyc.push_back(cyc);
         end
         hold = bus.rsp_valid && !bus.rsp_ready;
         hold_v = {bus.rsp_row, bus.rsp_data};
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic issue(input logic [CW-1:0] c, input logic [RW-1:0] r, output int waits);
      bit ok;
      ok = 1'b0;
      waits = 0;
      bus.req_valid = 1'b1;
      bus.req_char = c;
      bus.req_row = r;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.req_ready) ok = 1'b1;
         else waits++;
         @(posedge clk);
         #1;
         if (ok) break;
      end
      bus.req_valid = 1'b0;
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input string nm);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy) begin
            done = 1'b1;
            break;
         end
      end
      chk(nm, 32'(done), 32'd1);
      @(posedge clk);
      #1;
   endtask

   int w;
   int first;
   int nv;
   bit rnd_done;

   initial begin
      bus.req_valid = 1'b0;
      bus.req_char = '0;
      bus.req_row = '0;
      bus.rsp_ready = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_clk_en", 32'(rom_clk_en), 32'd0);
      chk("rst_addr", 32'(rom_addr), 32'd0);
      chk("rst_rsp_data", 32'({bus.rsp_row, bus.rsp_data}), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #1;

      // single read, latency LAT+1 edges from the accept edge
      issue(7'h41, 4'd3, w);
      chk("t1_addr", 32'(rom_addr), 32'h413);
      chk("t1_clk_en", 32'(rom_clk_en), 32'd1);
      first = 0;
      nv = 0;
      for (int k = 1; k <= LAT + 5; k++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin
            nv++;
            if (first == 0) first = k;
            chk("t1_row", 32'(bus.rsp_row), 32'd3);
         end
         if (k == 2) chk("t1_clk_en_low", 32'(rom_clk_en), 32'd0);
      end
      chk("t1_latency", 32'(first), 32'(LAT + 2));
      chk("t1_one_cycle", 32'(nv), 32'd1);
      @(posedge clk);
      #1;

      // 16 back-to-back reads, one response per cycle
      pop_cyc.delete();
      for (int r = 0; r < 16; r++) begin
         issue(7'h30, 4'(r), w);
         chk("t2_ready", 32'(w), 32'd0);
      end
      wait_idle("t2_drain");
      chk("t2_n_rsp", 32'(pop_cyc.size()), 32'd16);
      for (int i = 1; i < pop_cyc.size(); i++) begin
         chk("t2_spacing", 32'(pop_cyc[i] - pop_cyc[0]), 32'(i));
      end

      // backpressure: buffer fills after 4 accepts
      bus.rsp_ready = 1'b0;
      acc_cnt = 0;
      fork
         begin
            for (int r = 0; r < 6; r++) issue(7'h52, 4'(r), w);
         end
         begin
            repeat (12) @(negedge clk);
            chk("t3_accepts", 32'(acc_cnt), 32'd4);
            chk("t3_ready_low", 32'(bus.req_ready), 32'd0);
            chk("t3_head_row", 32'(bus.rsp_row), 32'd0);
            chk("t3_head_data", 32'(bus.rsp_data), 32'(glyph({7'h52, 4'd0})));
            @(posedge clk);
            #1 bus.rsp_ready = 1'b1;
         end
      join
      wait_idle("t3_drain");
      chk("t3_total", 32'(acc_cnt), 32'd6);

      // capture and pop in the same cycle at count=2
      bus.rsp_ready = 1'b0;
      issue(7'h21, 4'd1, w);
      issue(7'h21, 4'd2, w);
      repeat (LAT + 2) @(posedge clk);
      #1;
      chk("t4_cnt_pre", 32'(dut.u_fifo.o_count), 32'd2);
      issue(7'h21, 4'd3, w);
      repeat (LAT) @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
      chk("t4_cnt_post", 32'(dut.u_fifo.o_count), 32'd2);
      chk("t4_pending", 32'(exp_q.size()), 32'd2);
      bus.rsp_ready = 1'b1;
      wait_idle("t4_drain");

      // reset while reads are in flight
      issue(7'h33, 4'd4, w);
      issue(7'h33, 4'd5, w);
      rst_n = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < LAT + 4; k++) begin
         @(negedge clk);
         chk("t5_no_valid", 32'(bus.rsp_valid), 32'd0);
         chk("t5_busy", 32'(busy), 32'd0);
         chk("t5_ready", 32'(bus.req_ready), 32'd1);
      end
      @(posedge clk);
      #1;

      // randomized traffic with random consumer stalls
      rnd_done = 1'b0;
      fork
         begin
            for (int n = 0; n < 120; n++) begin
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
               issue(CW'($urandom_range(0, 127)), RW'($urandom_range(0, 15)), w);
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1 bus.rsp_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      bus.rsp_ready = 1'b1;
      wait_idle("rnd_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
